// File: rtl/exe_pipe_pkg.sv
// Shared opcode encodings and flag bit positions for the exe_pipe execute unit.
package exe_pkg;

   typedef logic [2:0] op_t;

   localparam op_t OP_ADD   = 3'd0;
   localparam op_t OP_SUB   = 3'd1;
   localparam op_t OP_SHIFT = 3'd2;
   localparam op_t OP_AND   = 3'd3;
   localparam op_t OP_ORR   = 3'd4;
   localparam op_t OP_XOR   = 3'd5;
   localparam op_t OP_XNOR  = 3'd6;
   localparam op_t OP_PASS  = 3'd7;

   localparam int FLAG_W = 4;
   localparam int FLAG_Z = 3;
   localparam int FLAG_N = 2;
   localparam int FLAG_C = 1;
   localparam int FLAG_V = 0;

endpackage

// File: rtl/exe_pipe_alu.sv
// Combinational 8-operation ALU producing a DATA_W result and {Z,N,C,V} flags.
module exe_alu
   import exe_pkg::*;
#(
   parameter int DATA_W = 10
) (
   input  op_t               oper_i,
   input  logic [DATA_W-1:0] a_i,
   input  logic [DATA_W-1:0] b_i,
   output logic [DATA_W-1:0] res_o,
   output logic [FLAG_W-1:0] flag_o
);

   localparam int SH_W = $clog2(DATA_W);
   localparam int MSB  = DATA_W - 1;

   logic [DATA_W:0]   sum;
   logic [DATA_W:0]   sh;
   logic [DATA_W-1:0] res;
   logic              c;
   logic              v;

   always_comb begin
      sum = '0;
      sh  = '0;
      res = '0;
      c   = 1'b0;
      v   = 1'b0;
      case (oper_i)
         OP_ADD: begin
            sum = {1'b0, a_i} + {1'b0, b_i};
            res = sum[DATA_W-1:0];
            c   = sum[DATA_W];
            v   = (a_i[MSB] == b_i[MSB]) && (res[MSB] != a_i[MSB]);
         end
         OP_SUB: begin
            sum = {1'b0, a_i} + {1'b0, ~b_i} + (DATA_W+1)'(1);
            res = sum[DATA_W-1:0];
            c   = sum[DATA_W];
            v   = (a_i[MSB] != b_i[MSB]) && (res[MSB] != a_i[MSB]);
         end
         OP_SHIFT: begin
            // One extra bit on top catches the last bit shifted out; large amounts clear everything.
            sh  = {1'b0, a_i} << b_i[SH_W-1:0];
            res = sh[DATA_W-1:0];
            c   = sh[DATA_W];
         end
         OP_AND:  res = a_i & b_i;
         OP_ORR:  res = a_i | b_i;
         OP_XOR:  res = a_i ^ b_i;
         OP_XNOR: res = ~(a_i ^ b_i);
         OP_PASS: res = b_i;
         default: res = '0;
      endcase
   end

   always_comb begin
      flag_o         = '0;
      flag_o[FLAG_Z] = (res == '0);
      flag_o[FLAG_N] = res[MSB];
      flag_o[FLAG_C] = c;
      flag_o[FLAG_V] = v;
   end

   assign res_o = res;

endmodule

// File: rtl/exe_pipe.sv
// Two-stage execute unit: register file, operand select, ALU, registered result.
// Build option EXE_PIPE_FWD_EN forwards the S1 result to issue operand reads.
module exe_pipe
   import exe_pkg::*;
#(
   parameter  int DATA_W = 10,
   parameter  int REG_N  = 16,
   localparam int RA_W   = $clog2(REG_N)
) (
   input  logic              i_clk,
   input  logic              i_rsn,
   input  logic              i_valid,
   output logic              o_ready,
   input  logic [2:0]        i_oper,
   input  logic [RA_W-1:0]   i_reg0,
   input  logic [RA_W-1:0]   i_reg1,
   input  logic              i_imm,
   input  logic [DATA_W-1:0] i_data,
   input  logic [RA_W-1:0]   i_dst,
   input  logic [RA_W-1:0]   i_reg2,
   input  logic [DATA_W-1:0] i_data2,
   output logic              o_valid,
   input  logic              i_ready,
   output logic [DATA_W-1:0] o_data,
   output logic [3:0]        o_flag
);

   logic [REG_N-1:0][DATA_W-1:0] rf_q;

   logic              s1_vld_q, s1_vld_d;
   op_t               s1_oper_q, s1_oper_d;
   logic [DATA_W-1:0] s1_a_q, s1_a_d;
   logic [DATA_W-1:0] s1_b_q, s1_b_d;
   logic [RA_W-1:0]   s1_dst_q, s1_dst_d;

   logic              s2_vld_q, s2_vld_d;
   logic [DATA_W-1:0] s2_data_q, s2_data_d;
   logic [FLAG_W-1:0] s2_flag_q, s2_flag_d;

   logic [DATA_W-1:0] alu_res;
   logic [FLAG_W-1:0] alu_flag;
   logic [DATA_W-1:0] op_a, op_b;
   logic              s2_free, s1_adv, s1_free, hazard, issue, wb_en;

   exe_alu #(.DATA_W(DATA_W)) u_alu (
      .oper_i (s1_oper_q),
      .a_i    (s1_a_q),
      .b_i    (s1_b_q),
      .res_o  (alu_res),
      .flag_o (alu_flag)
   );

   assign s2_free = !s2_vld_q || i_ready;
   assign s1_adv  = s1_vld_q && s2_free;
   assign s1_free = !s1_vld_q || s1_adv;
   assign wb_en   = s1_adv && (s1_dst_q != '0);

`ifdef EXE_PIPE_FWD_EN
   assign hazard = 1'b0;
`else
   // Without forwarding the write-back lands on the same edge the dependent
   // instruction would sample the register file, so hold it one cycle.
   assign hazard = s1_vld_q && (s1_dst_q != '0) &&
                   ((s1_dst_q == i_reg0) || (!i_imm && (s1_dst_q == i_reg1)));
`endif

   assign o_ready = s1_free && !hazard;
   assign issue   = i_valid && o_ready;

   function automatic logic [DATA_W-1:0] rd_op(input logic [RA_W-1:0] addr);
      logic [DATA_W-1:0] val;
      val = rf_q[addr];
`ifdef EXE_PIPE_FWD_EN
      if (s1_vld_q && (s1_dst_q == addr))
         val = alu_res;
`endif
      if (i_reg2 == addr)
         val = i_data2;
      if (addr == '0)
         val = '0;
      return val;
   endfunction

   always_comb begin
      op_a = rd_op(i_reg0);
      op_b = i_imm ? i_data : rd_op(i_reg1);
   end

   always_comb begin
      s1_vld_d  = s1_vld_q;
      s1_oper_d = s1_oper_q;
      s1_a_d    = s1_a_q;
      s1_b_d    = s1_b_q;
      s1_dst_d  = s1_dst_q;
      if (issue) begin
         s1_vld_d  = 1'b1;
         s1_oper_d = op_t'(i_oper);
         s1_a_d    = op_a;
         s1_b_d    = op_b;
         s1_dst_d  = i_dst;
      end else if (s1_adv) begin
         s1_vld_d  = 1'b0;
      end
   end

   always_comb begin
      s2_vld_d  = s2_vld_q;
      s2_data_d = s2_data_q;
      s2_flag_d = s2_flag_q;
      if (s1_adv) begin
         s2_vld_d  = 1'b1;
         s2_data_d = alu_res;
         s2_flag_d = alu_flag;
      end else if (i_ready) begin
         s2_vld_d  = 1'b0;
      end
   end

   always_ff @(posedge i_clk or negedge i_rsn) begin
      if (!i_rsn) begin
         s1_vld_q  <= 1'b0;
         s1_oper_q <= OP_ADD;
         s1_a_q    <= '0;
         s1_b_q    <= '0;
         s1_dst_q  <= '0;
         s2_vld_q  <= 1'b0;
         s2_data_q <= '0;
         s2_flag_q <= '0;
      end else begin
         s1_vld_q  <= s1_vld_d;
         s1_oper_q <= s1_oper_d;
         s1_a_q    <= s1_a_d;
         s1_b_q    <= s1_b_d;
         s1_dst_q  <= s1_dst_d;
         s2_vld_q  <= s2_vld_d;
         s2_data_q <= s2_data_d;
         s2_flag_q <= s2_flag_d;
      end
   end

   // External write is issued last so it wins a same-address collision.
   always_ff @(posedge i_clk or negedge i_rsn) begin
      if (!i_rsn) begin
         rf_q <= '0;
      end else begin
         if (wb_en)
            rf_q[s1_dst_q] <= alu_res;
         if (i_reg2 != '0)
            rf_q[i_reg2] <= i_data2;
      end
   end

   assign o_valid = s2_vld_q;
   assign o_data  = s2_data_q;
   assign o_flag  = s2_flag_q;

endmodule

// File: tb/tb_exe_pipe.sv
// Directed bench for exe_pipe: ALU vector table plus hazard, stall, collision and reset sequences.
module tb_exe_pipe;
   import exe_pkg::*;

   localparam int DATA_W = 10;
   localparam int REG_N  = 16;
   localparam int RA_W   = 4;
`ifdef EXE_PIPE_FWD_EN
   localparam int EXP_STALL = 0;
`else
   localparam int EXP_STALL = 1;
`endif

   logic              i_clk = 1'b0;
   logic              i_rsn = 1'b1;
   logic              i_valid = 1'b0;
   logic              o_ready;
   logic [2:0]        i_oper = '0;
   logic [RA_W-1:0]   i_reg0 = '0, i_reg1 = '0, i_dst = '0, i_reg2 = '0;
   logic              i_imm = 1'b0;
   logic [DATA_W-1:0] i_data = '0, i_data2 = '0;
   logic              o_valid;
   logic              i_ready = 1'b1;
   logic [DATA_W-1:0] o_data;
   logic [3:0]        o_flag;

   always #5 i_clk = ~i_clk;

   exe_pipe #(.DATA_W(DATA_W), .REG_N(REG_N)) dut (
      .i_clk(i_clk), .i_rsn(i_rsn), .i_valid(i_valid), .o_ready(o_ready),
      .i_oper(i_oper), .i_reg0(i_reg0), .i_reg1(i_reg1), .i_imm(i_imm),
      .i_data(i_data), .i_dst(i_dst), .i_reg2(i_reg2), .i_data2(i_data2),
      .o_valid(o_valid), .i_ready(i_ready), .o_data(o_data), .o_flag(o_flag)
   );

   int n_chk = 0;
   int n_pass = 0;
   logic [DATA_W-1:0] got_d[$];
   logic [3:0]        got_f[$];

   always @(negedge i_clk)
      if (i_rsn && o_valid && i_ready) begin
         got_d.push_back(o_data);
         got_f.push_back(o_flag);
      end

   typedef struct {
      op_t               op;
      logic [RA_W-1:0]   ra, rb;
      logic              imm;
      logic [DATA_W-1:0] d;
      logic [DATA_W-1:0] ed;
      logic [3:0]        ef;
   } vec_t;

   vec_t tv[16];

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h, want %0h", nm, act, exp);
   endtask

   task automatic drive(input op_t op, input logic [RA_W-1:0] ra, input logic [RA_W-1:0] rb,
                        input logic imm, input logic [DATA_W-1:0] d, input logic [RA_W-1:0] dst);
      i_oper = op; i_reg0 = ra; i_reg1 = rb; i_imm = imm; i_data = d; i_dst = dst;
      i_valid = 1'b1;
   endtask

   task automatic wait_accept(input string nm);
      bit ok = 0;
      for (int k = 0; k < 20; k++) begin
         @(negedge i_clk);
         if (o_ready) begin ok = 1; break; end
      end
      if (!ok) chk({nm, "_accept_timeout"}, 32'd0, 32'd1);
      @(posedge i_clk); #1;
      i_valid = 1'b0;
   endtask

   task automatic issue(input op_t op, input logic [RA_W-1:0] ra, input logic [RA_W-1:0] rb,
                        input logic imm, input logic [DATA_W-1:0] d, input logic [RA_W-1:0] dst);
      drive(op, ra, rb, imm, d, dst);
      wait_accept("issue");
   endtask

   task automatic ext_wr(input logic [RA_W-1:0] a, input logic [DATA_W-1:0] d);
      i_reg2 = a; i_data2 = d;
      @(posedge i_clk); #1;
      i_reg2 = '0;
   endtask

   task automatic wait_res(input int n);
      for (int k = 0; k < 30 && got_d.size() < n; k++) @(posedge i_clk);
      #1;
      if (got_d.size() < n) chk("result_timeout", 32'(got_d.size()), 32'(n));
   endtask

   task automatic pop_chk(input string nm, input logic [DATA_W-1:0] ed, input logic [3:0] ef);
      if (got_d.size() == 0) begin
         chk({nm, "_missing"}, 32'd0, 32'd1);
      end else begin
         chk({nm, "_data"}, 32'(got_d.pop_front()), 32'(ed));
         chk({nm, "_flag"}, 32'(got_f.pop_front()), 32'(ef));
      end
   endtask

   task automatic clr_q();
      got_d.delete();
      got_f.delete();
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      int stalls;
      bit ok;

      tv[0]  = '{OP_ADD,   4'd1,  4'd2, 1'b0, 10'd0,   10'd72,  4'b0000};
      tv[1]  = '{OP_SUB,   4'd1,  4'd4, 1'b0, 10'd0,   10'h3B8, 4'b0100};
      tv[2]  = '{OP_ADD,   4'd3,  4'd0, 1'b1, 10'd1,   10'h200, 4'b0101};
      tv[3]  = '{OP_SHIFT, 4'd10, 4'd0, 1'b1, 10'd1,   10'h002, 4'b0010};
      tv[4]  = '{OP_SHIFT, 4'd10, 4'd0, 1'b1, 10'd10,  10'h000, 4'b1010};
      tv[5]  = '{OP_SHIFT, 4'd10, 4'd0, 1'b1, 10'd0,   10'h201, 4'b0100};
      tv[6]  = '{OP_AND,   4'd7,  4'd8, 1'b0, 10'd0,   10'h080, 4'b0000};
      tv[7]  = '{OP_ORR,   4'd7,  4'd8, 1'b0, 10'd0,   10'h0E8, 4'b0000};
      tv[8]  = '{OP_XOR,   4'd7,  4'd8, 1'b0, 10'd0,   10'h068, 4'b0000};
      tv[9]  = '{OP_XNOR,  4'd7,  4'd8, 1'b0, 10'd0,   10'h397, 4'b0100};
      tv[10] = '{OP_PASS,  4'd1,  4'd0, 1'b1, 10'd0,   10'h000, 4'b1000};
      tv[11] = '{OP_ADD,   4'd0,  4'd0, 1'b1, 10'd0,   10'h000, 4'b1000};
      tv[12] = '{OP_SUB,   4'd5,  4'd5, 1'b0, 10'd0,   10'h000, 4'b1010};
      tv[13] = '{OP_SUB,   4'd3,  4'd0, 1'b1, 10'h3FF, 10'h200, 4'b0101};
      tv[14] = '{OP_ADD,   4'd10, 4'd0, 1'b1, 10'h3FF, 10'h200, 4'b0110};
      tv[15] = '{OP_PASS,  4'd1,  4'd9, 1'b0, 10'd0,   10'h0D8, 4'b0000};

      // Reset state
      #1 i_rsn = 1'b0;
      #10;
      chk("rst_o_valid", 32'(o_valid), 32'd0);
      chk("rst_o_data",  32'(o_data),  32'd0);
      chk("rst_o_flag",  32'(o_flag),  32'd0);
      chk("rst_o_ready", 32'(o_ready), 32'd1);
      @(posedge i_clk); #1 i_rsn = 1'b1;
      #1 chk("post_rst_o_ready", 32'(o_ready), 32'd1);

      for (int i = 1; i <= 9; i++) ext_wr(4'(i), 10'(24 * i));
      ext_wr(4'd3, 10'd511);
      ext_wr(4'd10, 10'h201);

      // ALU vector table: result is valid one edge after the accepting edge
      for (int i = 0; i < 16; i++) begin
         issue(tv[i].op, tv[i].ra, tv[i].rb, tv[i].imm, tv[i].d, 4'd0);
         @(posedge i_clk); #1;
         chk($sformatf("vec%0d_valid", i), 32'(o_valid), 32'd1);
         chk($sformatf("vec%0d_data", i),  32'(o_data),  32'(tv[i].ed));
         chk($sformatf("vec%0d_flag", i),  32'(o_flag),  32'(tv[i].ef));
      end
      @(posedge i_clk); #1;
      clr_q();

      // Dependent back-to-back: r9 = r7 + r8, then r9 + 27
      drive(OP_ADD, 4'd7, 4'd8, 1'b0, 10'd0, 4'd9);
      @(negedge i_clk);
      chk("dep_first_ready", 32'(o_ready), 32'd1);
      @(posedge i_clk); #1;
      drive(OP_ADD, 4'd9, 4'd0, 1'b1, 10'd27, 4'd0);
      stalls = 0; ok = 0;
      for (int k = 0; k < 10; k++) begin
         @(negedge i_clk);
         if (o_ready) begin ok = 1; break; end
         stalls++;
      end
      @(posedge i_clk); #1 i_valid = 1'b0;
      chk("dep_accepted", 32'(ok), 32'd1);
      chk("dep_stall_cycles", 32'(stalls), 32'(EXP_STALL));
      wait_res(2);
      pop_chk("dep_r9", 10'd360, 4'b0000);
      pop_chk("dep_r9p27", 10'd387, 4'b0000);

      // Back-pressure: three issues with the consumer stalled
      clr_q();
      i_ready = 1'b0;
      issue(OP_ORR, 4'd1, 4'd0, 1'b1, 10'd0, 4'd0);
      issue(OP_ORR, 4'd2, 4'd0, 1'b1, 10'd0, 4'd0);
      drive(OP_ORR, 4'd4, 4'd0, 1'b1, 10'd0, 4'd0);
      for (int k = 0; k < 3; k++) begin
         @(negedge i_clk);
         chk($sformatf("bp_ready_low%0d", k), 32'(o_ready), 32'd0);
         chk($sformatf("bp_data_hold%0d", k), 32'(o_data), 32'd24);
      end
      @(posedge i_clk); #1 i_ready = 1'b1;
      wait_accept("bp_third");
      wait_res(3);
      repeat (5) @(posedge i_clk);
      #1 chk("bp_result_count", 32'(got_d.size()), 32'd3);
      pop_chk("bp_r1", 10'd24, 4'b0000);
      pop_chk("bp_r2", 10'd48, 4'b0000);
      pop_chk("bp_r4", 10'd96, 4'b0000);

      // Collisions, r0 protection and write-through
      clr_q();
      issue(OP_ADD, 4'd1, 4'd0, 1'b1, 10'd0, 4'd5);
      ext_wr(4'd5, 10'd100);
      issue(OP_ORR, 4'd5, 4'd0, 1'b1, 10'd0, 4'd0);
      ext_wr(4'd0, 10'd55);
      issue(OP_ADD, 4'd0, 4'd0, 1'b1, 10'd0, 4'd0);
      i_reg2 = 4'd11; i_data2 = 10'd77;
      issue(OP_ORR, 4'd11, 4'd0, 1'b1, 10'd0, 4'd0);
      i_reg2 = '0;
      wait_res(4);
      pop_chk("col_wb", 10'd24, 4'b0000);
      pop_chk("col_r5", 10'd100, 4'b0000);
      pop_chk("col_r0", 10'd0, 4'b1000);
      pop_chk("wthru_r11", 10'd77, 4'b0000);

      // Reset while an instruction with dst=6 sits in S1
      clr_q();
      issue(OP_ADD, 4'd1, 4'd0, 1'b1, 10'd0, 4'd6);
      i_rsn = 1'b0;
      #1;
      chk("midrst_o_valid", 32'(o_valid), 32'd0);
      chk("midrst_o_ready", 32'(o_ready), 32'd1);
      @(posedge i_clk); #1 i_rsn = 1'b1;
      @(posedge i_clk); #1;
      chk("midrst_after_valid", 32'(o_valid), 32'd0);
      chk("midrst_after_ready", 32'(o_ready), 32'd1);
      issue(OP_ORR, 4'd6, 4'd0, 1'b1, 10'd0, 4'd0);
      issue(OP_ORR, 4'd1, 4'd0, 1'b1, 10'd0, 4'd0);
      wait_res(2);
      pop_chk("midrst_r6", 10'd0, 4'b1000);
      pop_chk("midrst_r1", 10'd0, 4'b1000);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
